// File: rtl/fp_divsqrt_seq_pkg.sv
// fp_divsqrt_seq_pkg: shared state and fc encodings for the fdiv/fsqrt sequencer
package fp_divsqrt_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ds_state_e;
  localparam logic [1:0] FC_DIV  = 2'b10;
  localparam logic [1:0] FC_SQRT = 2'b11;
endpackage

// File: rtl/fp_divsqrt_seq.sv
// fp_divsqrt_seq: launches, counts and releases fdiv/fsqrt on the shared iterative unit
// Optional stall-cycle counter is built only when FP_DS_PERF_EN is defined.
module fp_divsqrt_seq
  import fp_divsqrt_seq_pkg::*;
#(
  parameter int DIV_CYCLES  = 12,
  parameter int SQRT_CYCLES = 14,
  parameter int CW          = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          fv,
  input  logic [2:0]    fc,
  input  logic          e,
  input  logic          kill,
  output logic          start_div,
  output logic          start_sqrt,
  output logic          st_ds,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          res_valid,
  output logic [15:0]   perf_stall_cnt
);
  ds_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          op_q, op_d;
  logic          start_q, start_d;
  logic          is_ds, accept, unused_fc0;
  assign unused_fc0 = fc[0];
  always_comb begin
    is_ds   = (fc[2:1] == FC_DIV) || (fc[2:1] == FC_SQRT);
    accept  = (state_q == IDLE) && fv && is_ds && !kill;
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    start_d = 1'b0;
    if (accept) begin
      state_d = BUSY;
      op_d    = fc[2:1] == FC_SQRT;
      count_d = (fc[2:1] == FC_SQRT) ? CW'(SQRT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
      start_d = 1'b1;
    end else if (kill && state_q != IDLE) begin
      state_d = IDLE;
      count_d = '0;
    end else if (state_q == BUSY) begin
      state_d = (count_q == '0) ? DONE : BUSY;
      count_d = (count_q == '0) ? count_q : count_q - CW'(1);
    end else if (state_q == DONE && e) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      start_q <= start_d;
    end
  end
  assign start_div  = start_q && !op_q;
  assign start_sqrt = start_q && op_q;
  assign st_ds      = accept || state_q == BUSY;
  assign busy       = state_q == BUSY || state_q == DONE;
  assign res_valid  = state_q == DONE;
  assign count      = count_q;
`ifdef FP_DS_PERF_EN
  logic [15:0] perf_q, perf_d;
  always_comb perf_d = (st_ds && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
  always_ff @(posedge clk) begin
    if (clrn) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fp_divsqrt_seq.sv
// tb_fp_divsqrt_seq: directed table plus random traffic against a transaction-timeline model
module tb_fp_divsqrt_seq;
`ifdef FP_DS_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int P13 = PERF ? 13 : 0;
  logic clk = 1'b0, clrn = 1'b1, fv = 1'b0, e = 1'b1, kill = 1'b0;
  logic [2:0] fc = 3'b000;
  logic start_div, start_sqrt, st_ds, busy, res_valid;
  logic [4:0] count;
  logic [15:0] perf_stall_cnt;
  int errors = 0, checks = 0;
  fp_divsqrt_seq dut (
    .clk(clk), .clrn(clrn), .fv(fv), .fc(fc), .e(e), .kill(kill),
    .start_div(start_div), .start_sqrt(start_sqrt), .st_ds(st_ds), .busy(busy),
    .count(count), .res_valid(res_valid), .perf_stall_cnt(perf_stall_cnt)
  );
  always #5 clk = ~clk;
  // model: one outstanding op, k = cycles since accept; BUSY while k<=n, DONE after
  bit act = 0, sq = 0;
  int k = 0, n = 0, perf = 0;
  task automatic chk(input string name, input int a, input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, a, x);
    end
  endtask
  function automatic bit m_acc();
    return !act && fv && fc[2] && !kill;
  endfunction
  function automatic bit m_bsy();
    return act && k <= n;
  endfunction
  task automatic check_model();
    chk("st_ds", int'(st_ds), int'(m_acc() | m_bsy()));
    chk("busy", int'(busy), int'(act));
    chk("count", int'(count), m_bsy() ? n - k : 0);
    chk("start_div", int'(start_div), int'(act && k == 1 && !sq));
    chk("start_sqrt", int'(start_sqrt), int'(act && k == 1 && sq));
    chk("res_valid", int'(res_valid), int'(act && k > n));
    chk("perf", int'(perf_stall_cnt), PERF ? perf : 0);
  endtask
  task automatic update_model();
    bit acc = m_acc(), bsy = m_bsy();
    if (clrn) begin
      act = 0; perf = 0;
    end else begin
      if ((acc || bsy) && perf < 65535) perf++;
      if (acc) begin
        act = 1; k = 1; sq = fc[1]; n = sq ? 14 : 12;
      end else if (act && kill) act = 0;
      else if (act && k > n) begin
        if (e) act = 0;
      end else if (act) k++;
    end
  endtask
  typedef struct {
    bit fv; bit [2:0] fc; bit e, kill, clrn; int len;
    bit st, bz, rv, sd, ss; int cnt; int perf;
  } rec_t;
  rec_t tbl[$];
  task automatic add(input bit f, input bit [2:0] c, input bit ee, input bit kl, input bit rs, input int len,
                     input bit st, input bit bz, input bit rv, input bit sd, input bit ss, input int cnt, input int pf);
    rec_t r;
    r.fv = f; r.fc = c; r.e = ee; r.kill = kl; r.clrn = rs; r.len = len;
    r.st = st; r.bz = bz; r.rv = rv; r.sd = sd; r.ss = ss; r.cnt = cnt; r.perf = pf;
    tbl.push_back(r);
  endtask
  task automatic tick(input bit en);
    @(negedge clk);
    if (en) check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask
  initial begin
    tick(0);
    tick(0);
    clrn = 0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_perf", int'(perf_stall_cnt), 0);
    // fdiv issue
    add(1,3'b100,1,0,0,1,  1,0,0,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  1,1,0,1,0,11,-1);
    add(0,3'b000,1,0,0,11, 1,1,0,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  0,1,1,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  0,0,0,0,0,0,-1);
    // fsqrt with DONE held by e=0
    add(1,3'b110,1,0,0,1,  1,0,0,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  1,1,0,0,1,13,-1);
    add(0,3'b000,1,0,0,13, 1,1,0,0,0,0,-1);
    add(0,3'b000,0,0,0,2,  0,1,1,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  0,1,1,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  0,0,0,0,0,0,-1);
    // kill mid-BUSY
    add(1,3'b100,1,0,0,1,  1,0,0,0,0,0,-1);
    add(0,3'b000,1,0,0,4,  1,1,0,0,0,8,-1);
    add(0,3'b000,1,1,0,1,  1,1,0,0,0,7,-1);
    add(0,3'b000,1,0,0,1,  0,0,0,0,0,0,-1);
    // reset mid-fsqrt, then immediate fdiv
    add(1,3'b110,1,0,0,1,  1,0,0,0,0,0,-1);
    add(0,3'b000,1,0,0,6,  1,1,0,0,0,8,-1);
    add(0,3'b000,1,0,1,1,  1,1,0,0,0,7,-1);
    add(1,3'b100,1,0,0,1,  1,0,0,0,0,0,0);
    add(0,3'b000,1,0,0,1,  1,1,0,1,0,11,-1);
    add(0,3'b000,1,0,0,12, 0,1,1,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  0,0,0,0,0,0,P13);
    // back-to-back fdiv held in ID, then non-div fc
    add(1,3'b100,1,0,0,1,  1,0,0,0,0,0,-1);
    add(1,3'b100,1,0,0,12, 1,1,0,0,0,0,-1);
    add(1,3'b100,1,0,0,1,  0,1,1,0,0,0,-1);
    add(1,3'b100,1,0,0,1,  1,0,0,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  1,1,0,1,0,11,-1);
    add(0,3'b000,1,0,0,11, 1,1,0,0,0,0,-1);
    add(0,3'b000,1,0,0,1,  0,1,1,0,0,0,-1);
    add(1,3'b000,1,0,0,3,  0,0,0,0,0,0,-1);
    // kill while DONE
    add(1,3'b100,1,0,0,1,  1,0,0,0,0,0,-1);
    add(0,3'b000,1,0,0,12, 1,1,0,0,0,0,-1);
    add(0,3'b000,0,0,0,1,  0,1,1,0,0,0,-1);
    add(0,3'b000,0,1,0,1,  0,1,1,0,0,0,-1);
    add(0,3'b000,0,0,0,1,  0,0,0,0,0,0,-1);
    foreach (tbl[i]) begin
      fv = tbl[i].fv; fc = tbl[i].fc; e = tbl[i].e; kill = tbl[i].kill; clrn = tbl[i].clrn;
      for (int j = 0; j < tbl[i].len; j++) begin
        @(negedge clk);
        check_model();
        if (j == tbl[i].len - 1) begin
          chk($sformatf("t%0d_st_ds", i), int'(st_ds), int'(tbl[i].st));
          chk($sformatf("t%0d_busy", i), int'(busy), int'(tbl[i].bz));
          chk($sformatf("t%0d_res_valid", i), int'(res_valid), int'(tbl[i].rv));
          chk($sformatf("t%0d_start_div", i), int'(start_div), int'(tbl[i].sd));
          chk($sformatf("t%0d_start_sqrt", i), int'(start_sqrt), int'(tbl[i].ss));
          chk($sformatf("t%0d_count", i), int'(count), tbl[i].cnt);
          if (tbl[i].perf >= 0) chk($sformatf("t%0d_perf", i), int'(perf_stall_cnt), tbl[i].perf);
        end
        @(posedge clk);
        update_model();
        #1;
      end
    end
    for (int i = 0; i < 600; i++) begin
      clrn = $urandom_range(0, 149) == 0;
      kill = $urandom_range(0, 24) == 0;
      fv   = 1'($urandom_range(0, 1));
      fc   = 3'($urandom);
      e    = $urandom_range(0, 3) != 0;
      tick(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
